branch_resolve: RTL and testbench

- Execute-side counterpart of the fetch PC/branch predictor.
- Records every conditional branch that fetch issues, together with the fetch-time taken/not-taken prediction, in an in-order queue.
- When execute resolves a branch, compares the actual outcome against the recorded prediction.
- Drives jump_cause/jump_from/jump_to back to the PC block: corrective redirects, unconditional jumps, interrupts and exceptions. These outputs update the predictor FSM and flush the pipe.

---
 rtl/branch_resolve.sv | 146 ++++++++++++++
 tb/tb_branch_resolve.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// Execute-side branch resolution: queues fetch-time predictions and drives redirects back to the PC block.
// Optional BRANCH_STATS_EN adds saturating resolved/mispredict counters.
`ifndef BRANCH_RESOLVE_DEFS
`define BRANCH_RESOLVE_DEFS
`define HOLDPIP_BUS 2:0
`define HOLD_NO 3'b000
`define INST_B 7'b1100011
`define PREDICT_JUMP_ENABLE 1'b1
`define JUMP_CAUSE_BUS 2:0
`define JUMP_CAUSE_NO 3'd0
`define JUMP_CAUSE_PREDICT_NO_BUT_YES 3'd1
`define JUMP_CAUSE_PREDICT_YES_BUT_NO 3'd2
`define JUMP_CAUSE_NOCONDITION 3'd3
`define JUMP_CAUSE_INTERRUPT 3'd4
`define JUMP_CAUSE_EXCEPTION 3'd5
`endif

module branch_resolve #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [`HOLDPIP_BUS]    hold_flag_i,
    input  logic [31:0]            fetch_pc_i,
    input  logic [31:0]            fetch_inst_i,
    input  logic                   predict_to_jump_i,
    input  logic                   resolve_valid_i,
    input  logic [31:0]            resolve_pc_i,
    input  logic                   resolve_taken_i,
    input  logic [31:0]            resolve_target_i,
    input  logic                   uncond_valid_i,
    input  logic [31:0]            uncond_pc_i,
    input  logic [31:0]            uncond_target_i,
    input  logic                   irq_valid_i,
    input  logic                   exc_valid_i,
    input  logic [31:0]            trap_target_i,
    output logic [`JUMP_CAUSE_BUS] jump_cause_o,
    output logic [31:0]            jump_from_addr_o,
    output logic [31:0]            jump_to_addr_o,
    output logic                   queue_full_o,
    output logic                   resolve_mismatch_o
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]            stat_resolved_o,
    output logic [31:0]            stat_mispredict_o
`endif
);

    logic [DEPTH-1:0][31:0] q_pc;
    logic [DEPTH-1:0]       q_flag;
    logic [PTR_W-1:0]       rd_ptr, wr_ptr;
    logic [PTR_W:0]         count;

    logic                   head_hit, predicted, redirect, push, pop;
    logic [`JUMP_CAUSE_BUS] cause_nxt;
    logic [31:0]            from_nxt, to_nxt;
    logic                   unused_inst;

    assign unused_inst  = ^fetch_inst_i[31:7];
    assign queue_full_o = (count == (PTR_W+1)'(DEPTH));
    assign head_hit     = (count != '0) && (q_pc[rd_ptr] == resolve_pc_i);
    // An unmatched resolve is treated as a not-taken prediction.
    assign predicted    = head_hit && (q_flag[rd_ptr] == `PREDICT_JUMP_ENABLE);

    always_comb begin
        cause_nxt = `JUMP_CAUSE_NO;
        from_nxt  = '0;
        to_nxt    = '0;
        if (exc_valid_i) begin
            cause_nxt = `JUMP_CAUSE_EXCEPTION;
            to_nxt    = trap_target_i;
        end else if (irq_valid_i) begin
            cause_nxt = `JUMP_CAUSE_INTERRUPT;
            to_nxt    = trap_target_i;
        end else if (resolve_valid_i && predicted && !resolve_taken_i) begin
            cause_nxt = `JUMP_CAUSE_PREDICT_YES_BUT_NO;
            from_nxt  = resolve_pc_i;
            to_nxt    = resolve_pc_i + 32'd4;
        end else if (resolve_valid_i && !predicted && resolve_taken_i) begin
            cause_nxt = `JUMP_CAUSE_PREDICT_NO_BUT_YES;
            from_nxt  = resolve_pc_i;
            to_nxt    = resolve_target_i;
        end else if (uncond_valid_i) begin
            cause_nxt = `JUMP_CAUSE_NOCONDITION;
            from_nxt  = uncond_pc_i;
            to_nxt    = uncond_target_i;
        end
    end

    assign redirect = (cause_nxt != `JUMP_CAUSE_NO);
    assign pop      = resolve_valid_i && head_hit && !redirect;
    assign push     = (fetch_inst_i[6:0] == `INST_B) && (hold_flag_i == `HOLD_NO)
                      && !queue_full_o && !redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            jump_cause_o       <= `JUMP_CAUSE_NO;
            jump_from_addr_o   <= '0;
            jump_to_addr_o     <= '0;
            resolve_mismatch_o <= 1'b0;
            rd_ptr             <= '0;
            wr_ptr             <= '0;
            count              <= '0;
        end else begin
            jump_cause_o       <= cause_nxt;
            jump_from_addr_o   <= from_nxt;
            jump_to_addr_o     <= to_nxt;
            resolve_mismatch_o <= resolve_valid_i && !head_hit;
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
            end
        end
    end

    // Entry storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]   <= fetch_pc_i;
            q_flag[wr_ptr] <= predict_to_jump_i;
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_resolved_o   <= '0;
            stat_mispredict_o <= '0;
        end else begin
            if (resolve_valid_i && stat_resolved_o != 32'hFFFF_FFFF)
                stat_resolved_o <= stat_resolved_o + 32'd1;
            if ((cause_nxt == `JUMP_CAUSE_PREDICT_NO_BUT_YES ||
                 cause_nxt == `JUMP_CAUSE_PREDICT_YES_BUT_NO) &&
                stat_mispredict_o != 32'hFFFF_FFFF)
                stat_mispredict_o <= stat_mispredict_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: directed scenarios then random traffic vs. a queue-based model.
`ifndef BRANCH_RESOLVE_DEFS
`define BRANCH_RESOLVE_DEFS
`define HOLDPIP_BUS 2:0
`define HOLD_NO 3'b000
`define INST_B 7'b1100011
`define PREDICT_JUMP_ENABLE 1'b1
`define JUMP_CAUSE_BUS 2:0
`define JUMP_CAUSE_NO 3'd0
`define JUMP_CAUSE_PREDICT_NO_BUT_YES 3'd1
`define JUMP_CAUSE_PREDICT_YES_BUT_NO 3'd2
`define JUMP_CAUSE_NOCONDITION 3'd3
`define JUMP_CAUSE_INTERRUPT 3'd4
`define JUMP_CAUSE_EXCEPTION 3'd5
`endif

module tb_branch_resolve;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] BR  = 32'h0000_0063;

    logic clk = 0, rst = 1;
    logic [`HOLDPIP_BUS] hold;
    logic [31:0] f_pc, f_inst, r_pc, r_tgt, u_pc, u_tgt, trap;
    logic pred, r_v, r_tk, u_v, irq, exc;
    logic [`JUMP_CAUSE_BUS] cause;
    logic [31:0] from, to;
    logic full, mism;
`ifdef BRANCH_STATS_EN
    logic [31:0] st_res, st_mis;
    logic [31:0] m_res = 0, m_mis = 0;
`endif

    branch_resolve #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk(clk), .rst(rst), .hold_flag_i(hold),
        .fetch_pc_i(f_pc), .fetch_inst_i(f_inst), .predict_to_jump_i(pred),
        .resolve_valid_i(r_v), .resolve_pc_i(r_pc), .resolve_taken_i(r_tk),
        .resolve_target_i(r_tgt), .uncond_valid_i(u_v), .uncond_pc_i(u_pc),
        .uncond_target_i(u_tgt), .irq_valid_i(irq), .exc_valid_i(exc),
        .trap_target_i(trap), .jump_cause_o(cause), .jump_from_addr_o(from),
        .jump_to_addr_o(to), .queue_full_o(full), .resolve_mismatch_o(mism)
`ifdef BRANCH_STATS_EN
        , .stat_resolved_o(st_res), .stat_mispredict_o(st_mis)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic flag; } ent_t;
    typedef struct { logic [2:0] cause; logic [31:0] from, to; logic mism, full; } exp_t;
    ent_t mq[$];
    exp_t exp_q[$];
    int vectors = 0, miscompares = 0;

    task automatic chk(string n, logic [31:0] got, logic [31:0] want);
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s t=%0t got=%h want=%h", n, $time, got, want);
        end
    endtask

    task automatic idle();
        hold = `HOLD_NO; f_pc = 0; f_inst = NOP; pred = 0;
        r_v = 0; r_pc = 0; r_tk = 0; r_tgt = 0;
        u_v = 0; u_pc = 0; u_tgt = 0; irq = 0; exc = 0; trap = 0;
    endtask

    // Reference: apply this cycle's rules to the model queue, record the expected registered outputs.
    task automatic tick();
        exp_t e;
        bit hit, p, redirect, was_full, mispred;
        hit = (mq.size() > 0) && (mq[0].pc == r_pc);
        p   = hit && mq[0].flag;
        e = '{cause: `JUMP_CAUSE_NO, from: 0, to: 0, mism: r_v && !hit, full: 0};
        if (exc)                  begin e.cause = `JUMP_CAUSE_EXCEPTION; e.to = trap; end
        else if (irq)             begin e.cause = `JUMP_CAUSE_INTERRUPT; e.to = trap; end
        else if (r_v && p && !r_tk) begin e.cause = `JUMP_CAUSE_PREDICT_YES_BUT_NO; e.from = r_pc; e.to = r_pc + 4; end
        else if (r_v && !p && r_tk) begin e.cause = `JUMP_CAUSE_PREDICT_NO_BUT_YES; e.from = r_pc; e.to = r_tgt; end
        else if (u_v)             begin e.cause = `JUMP_CAUSE_NOCONDITION; e.from = u_pc; e.to = u_tgt; end
        redirect = (e.cause != `JUMP_CAUSE_NO);
        mispred  = (e.cause == `JUMP_CAUSE_PREDICT_YES_BUT_NO) || (e.cause == `JUMP_CAUSE_PREDICT_NO_BUT_YES);
        was_full = (mq.size() == DEPTH);
        if (redirect) mq.delete();
        else begin
            if (r_v && hit) void'(mq.pop_front());
            if (f_inst[6:0] == `INST_B && hold == `HOLD_NO && !was_full)
                mq.push_back('{pc: f_pc, flag: pred});
        end
        e.full = (mq.size() == DEPTH);
`ifdef BRANCH_STATS_EN
        if (r_v && m_res != 32'hFFFF_FFFF) m_res++;
        if (mispred && m_mis != 32'hFFFF_FFFF) m_mis++;
`else
        if (mispred) begin end
`endif
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic fetch_br(logic [31:0] pc, logic pr);
        f_inst = BR; f_pc = pc; pred = pr;
    endtask

    // Monitor: every cycle the DUT produces a registered result, pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                chk("cause", 32'(cause), 32'(e.cause));
                if (e.cause != `JUMP_CAUSE_NO) chk("to", to, e.to);
                if (e.cause inside {`JUMP_CAUSE_PREDICT_NO_BUT_YES, `JUMP_CAUSE_PREDICT_YES_BUT_NO,
                                    `JUMP_CAUSE_NOCONDITION}) chk("from", from, e.from);
                chk("mismatch", 32'(mism), 32'(e.mism));
                chk("full", 32'(full), 32'(e.full));
`ifdef BRANCH_STATS_EN
                chk("stat_resolved", st_res, m_res);
                chk("stat_mispredict", st_mis, m_mis);
`endif
            end
        end
    end

    initial begin
        idle();
        #12;
        vectors++;
        chk("rst_cause", 32'(cause), 32'(`JUMP_CAUSE_NO));
        chk("rst_from", from, 0);
        chk("rst_to", to, 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_mism", 32'(mism), 0);
        @(negedge clk); rst = 0;

        // predicted taken, actually not taken
        fetch_br(32'h100, 1); tick(); idle();
        r_v = 1; r_pc = 32'h100; r_tk = 0; tick(); idle();
        tick();
        // predicted not taken, actually taken
        fetch_br(32'h200, 0); tick(); idle();
        r_v = 1; r_pc = 32'h200; r_tk = 1; r_tgt = 32'h180; tick(); idle();
        // fill queue, fifth push dropped, then drain in order
        for (int i = 0; i < 5; i++) begin fetch_br(32'h300 + 4*i, 0); tick(); end
        idle();
        for (int i = 0; i < 5; i++) begin r_v = 1; r_pc = 32'h300 + 4*i; r_tk = 0; tick(); end
        idle();
        // exception beats irq and mispredict, flushes queue and same-cycle push
        fetch_br(32'h500, 1); tick(); idle();
        exc = 1; irq = 1; trap = 32'h80; r_v = 1; r_pc = 32'h500; r_tk = 0;
        fetch_br(32'h504, 1); tick(); idle();
        // empty queue resolve
        r_v = 1; r_pc = 32'h500; r_tk = 1; r_tgt = 32'h40; tick(); idle();
        // irq beats uncond
        irq = 1; trap = 32'h90; u_v = 1; u_pc = 32'h600; u_tgt = 32'h700; tick(); idle();
        u_v = 1; u_pc = 32'h604; u_tgt = 32'h800; tick(); idle();
        // PC wrap on not-taken correction
        fetch_br(32'hFFFF_FFFC, 1); tick(); idle();
        r_v = 1; r_pc = 32'hFFFF_FFFC; r_tk = 0; tick(); idle();
        // correct resolve plus push in the same cycle
        fetch_br(32'h900, 1); tick();
        fetch_br(32'h904, 0); r_v = 1; r_pc = 32'h900; r_tk = 1; tick(); idle();
        r_v = 1; r_pc = 32'h904; r_tk = 0; tick(); idle();

        // async reset during a redirect
        exc = 1; trap = 32'hA0; tick(); idle();
        rst = 1; #1;
        vectors++;
        chk("async_rst_cause", 32'(cause), 32'(`JUMP_CAUSE_NO));
        chk("async_rst_to", to, 0);
        mq.delete(); exp_q.delete();
`ifdef BRANCH_STATS_EN
        m_res = 0; m_mis = 0;
`endif
        @(negedge clk); rst = 0;

        for (int c = 0; c < 400; c++) begin
            idle();
            hold = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : `HOLD_NO;
            f_inst = {$urandom, 7'h00} | (($urandom_range(0, 1) == 1) ? 32'h63 : 32'h13);
            f_pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            pred = 1'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                r_v = 1; r_tk = 1'($urandom); r_tgt = $urandom;
                r_pc = (mq.size() > 0 && $urandom_range(0, 7) != 0) ? mq[0].pc : $urandom;
            end
            u_v = ($urandom_range(0, 9) == 0); u_pc = $urandom; u_tgt = $urandom;
            irq = ($urandom_range(0, 29) == 0);
            exc = ($urandom_range(0, 29) == 0);
            trap = $urandom;
            tick();
        end
        idle(); tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
